patching_cache_multilane: RTL and testbench

- Parametrised successor to the single-activation patching top.
- Stores activation vectors of LANES x N bits in a direct-mapped, tagged cache of DEPTH lines. Each line carries a per-lane patch mask.
- On a read, each output lane is either the cached (patched) activation or the original activation supplied by the datapath, selected by the stored mask.
- Sits between the activation fetch path and the PE array. Uses a valid/ready request/response handshake with one outstanding transaction.

---
 rtl/patching_cache_multilane.sv | 176 +++++++++++++++++
 tb/tb_patching_cache_multilane.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/patching_cache_multilane.sv
// Direct-mapped patch cache: a per-lane mask picks cached or original activation; PATCH_CACHE_STATS_EN adds counters.
// Latency: response registered two cycles after the request cycle; one transaction in flight (IDLE/LOOKUP/RESP).
// Backpressure: response held while resp_ready=0; req_ready stays low until the response handshake.
module patching_cache_multilane #(
    parameter int N          = 16,
    parameter int LANES      = 4,
    parameter int DEPTH      = 64,
    parameter int ADDR_WIDTH = 21,
    parameter logic [ADDR_WIDTH-1:0] ADDR_LIMIT = {ADDR_WIDTH{1'b1}}
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  read_write,
    input  logic [ADDR_WIDTH-1:0] address,
    input  logic [LANES*N-1:0]    activation_in,
    input  logic [LANES-1:0]      patch_mask_in,
    input  logic [LANES*N-1:0]    activation_org,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [LANES*N-1:0]    chosen_activation,
    output logic                  hit,
    output logic                  error
`ifdef PATCH_CACHE_STATS_EN
    ,
    output logic [31:0]           stat_hits,
    output logic [31:0]           stat_misses,
    output logic [31:0]           stat_patched_lanes
`endif
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = ADDR_WIDTH - IDX_W;
    localparam int W     = LANES * N;

    typedef enum logic [1:0] {IDLE, LOOKUP, RESP} state_t;
    state_t state_q, state_d;

    logic                  rw_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [W-1:0]          act_q;
    logic [W-1:0]          org_q;
    logic [LANES-1:0]      mask_q;

    logic [DEPTH-1:0]      line_vld;
    logic [TAG_W-1:0]      line_tag  [DEPTH];
    logic [W-1:0]          line_dat  [DEPTH];
    logic [LANES-1:0]      line_mask [DEPTH];

    logic [IDX_W-1:0]      idx;
    logic [TAG_W-1:0]      tag;
    logic                  addr_err;
    logic                  lookup_hit;
    logic                  do_write;
    logic [W-1:0]          chosen_d;

    assign idx        = addr_q[IDX_W-1:0];
    assign tag        = addr_q[ADDR_WIDTH-1:IDX_W];
    assign addr_err   = addr_q > ADDR_LIMIT;
    assign lookup_hit = rw_q && line_vld[idx] && (line_tag[idx] == tag) && !addr_err;
    assign do_write   = (state_q == LOOKUP) && !rw_q && !addr_err;
    assign req_ready  = (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (req_valid) state_d = LOOKUP;
            LOOKUP:  state_d = RESP;
            RESP:    if (resp_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Request fields are captured only on acceptance, so a request presented during RESP is never sampled.
    always_ff @(posedge clk) begin
        if (!reset && req_ready && req_valid) begin
            rw_q   <= read_write;
            addr_q <= address;
            act_q  <= activation_in;
            mask_q <= patch_mask_in;
            org_q  <= activation_org;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            line_vld <= '0;
        end else if (do_write) begin
            line_vld[idx] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && do_write) begin
            line_tag[idx]  <= tag;
            line_dat[idx]  <= act_q;
            line_mask[idx] <= mask_q;
        end
    end

    always_comb begin
        chosen_d = org_q;
        for (int i = 0; i < LANES; i++) begin
            if (lookup_hit && line_mask[idx][i]) begin
                chosen_d[i*N +: N] = line_dat[idx][i*N +: N];
            end
        end
    end

    // Response fields are loaded once at the end of LOOKUP and then held until the handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid        <= 1'b0;
            hit               <= 1'b0;
            error             <= 1'b0;
            chosen_activation <= '0;
        end else if (state_q == LOOKUP) begin
            resp_valid        <= 1'b1;
            hit               <= lookup_hit;
            error             <= addr_err;
            chosen_activation <= rw_q ? chosen_d : '0;
        end else if ((state_q == RESP) && resp_ready) begin
            resp_valid        <= 1'b0;
        end
    end

`ifdef PATCH_CACHE_STATS_EN
    logic [31:0] pop_d;
    logic [31:0] pop_q;
    logic        rd_hs;

    function automatic logic [31:0] sat_add(input logic [31:0] a, input logic [31:0] b);
        logic [32:0] s;
        s = {1'b0, a} + {1'b0, b};
        return s[32] ? 32'hFFFF_FFFF : s[31:0];
    endfunction

    always_comb begin
        pop_d = '0;
        for (int i = 0; i < LANES; i++) begin
            if (line_mask[idx][i]) pop_d = pop_d + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (state_q == LOOKUP) begin
            pop_q <= lookup_hit ? pop_d : 32'd0;
        end
    end

    assign rd_hs = (state_q == RESP) && resp_ready && rw_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            stat_hits          <= '0;
            stat_misses        <= '0;
            stat_patched_lanes <= '0;
        end else if (rd_hs) begin
            if (hit) begin
                stat_hits          <= sat_add(stat_hits, 32'd1);
                stat_patched_lanes <= sat_add(stat_patched_lanes, pop_q);
            end else if (!error) begin
                stat_misses        <= sat_add(stat_misses, 32'd1);
            end
        end
    end
`endif
endmodule

// File: tb/tb_patching_cache_multilane.sv
// Directed bench for patching_cache_multilane with a line-level reference model and a per-cycle response checker.
module tb_patching_cache_multilane;
    localparam int N     = 16;
    localparam int LANES = 4;
    localparam int DEPTH = 64;
    localparam int AW    = 21;
    localparam int W     = LANES * N;
    localparam logic [AW-1:0] LIMIT = 21'd100;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          read_write = 1'b0;
    logic [AW-1:0] address = '0;
    logic [W-1:0]  activation_in = '0;
    logic [3:0]    patch_mask_in = '0;
    logic [W-1:0]  activation_org = '0;
    logic          resp_valid;
    logic          resp_ready = 1'b1;
    logic [W-1:0]  chosen_activation;
    logic          hit;
    logic          error;
`ifdef PATCH_CACHE_STATS_EN
    logic [31:0]   stat_hits, stat_misses, stat_patched_lanes;
`endif

    always #5 clk = ~clk;

    patching_cache_multilane #(
        .N(N), .LANES(LANES), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .ADDR_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
        .read_write(read_write), .address(address), .activation_in(activation_in),
        .patch_mask_in(patch_mask_in), .activation_org(activation_org),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .chosen_activation(chosen_activation), .hit(hit), .error(error)
`ifdef PATCH_CACHE_STATS_EN
        , .stat_hits(stat_hits), .stat_misses(stat_misses), .stat_patched_lanes(stat_patched_lanes)
`endif
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act === req) n_pass++;
        else $display("FAIL %s: got %h, expected %h", name, act, req);
    endtask

    function automatic logic [63:0] pk(input logic [15:0] l0, l1, l2, l3);
        return {l3, l2, l1, l0};
    endfunction

    // Reference: each slot remembers the full address it was written with, so a hit is just an address match.
    bit            mvld  [DEPTH];
    logic [AW-1:0] maddr [DEPTH];
    logic [W-1:0]  mdat  [DEPTH];
    logic [3:0]    mmask [DEPTH];
    int            m_hits = 0, m_misses = 0, m_pl = 0;

    logic          exp_pend = 1'b0;
    logic          exp_hit = 1'b0, exp_err = 1'b0;
    logic [W-1:0]  exp_chosen = '0;
    logic          last_hit = 1'b0, last_err = 1'b0;
    logic [W-1:0]  last_chosen = '0;

    logic          q_rw = 1'b0;
    logic [AW-1:0] q_a = '0;
    logic [W-1:0]  q_dat = '0, q_org = '0;
    logic [3:0]    q_m = '0;

    always @(posedge clk) begin
        #1;
        if (!reset && resp_valid) begin
            if (!exp_pend) begin
                chk("spurious_resp", {63'b0, resp_valid}, 64'd0);
            end else begin
                chk("resp_hit", {63'b0, hit}, {63'b0, exp_hit});
                chk("resp_error", {63'b0, error}, {63'b0, exp_err});
                chk("resp_chosen", chosen_activation, exp_chosen);
                last_hit    = hit;
                last_err    = error;
                last_chosen = chosen_activation;
            end
        end
    end

    // Called at a negedge with the DUT idle; returns at the negedge after the response handshake.
    task automatic txn(input logic rw, input logic [AW-1:0] a, input logic [W-1:0] dat,
                       input logic [3:0] m, input logic [W-1:0] org, input int stall);
        int ix;
        bit err;
        ix  = int'(a % DEPTH);
        err = (a > LIMIT);
        exp_err = err;
        exp_hit = rw && !err && mvld[ix] && (maddr[ix] == a);
        exp_chosen = '0;
        if (rw) begin
            for (int i = 0; i < LANES; i++)
                exp_chosen[i*N +: N] = (exp_hit && mmask[ix][i]) ? mdat[ix][i*N +: N] : org[i*N +: N];
        end
        exp_pend = 1'b1;
        chk("req_ready_idle", {63'b0, req_ready}, 64'd1);
        req_valid = 1'b1; read_write = rw; address = a; activation_in = dat;
        patch_mask_in = m; activation_org = org; resp_ready = (stall == 0);
        @(negedge clk);
        req_valid = 1'b0;
        chk("lookup_no_resp", {63'b0, resp_valid}, 64'd0);
        @(negedge clk);
        chk("resp_latency", {63'b0, resp_valid}, 64'd1);
        for (int s = 0; s < stall; s++) begin
            chk("stall_req_ready", {63'b0, req_ready}, 64'd0);
            req_valid = 1'b1; read_write = q_rw; address = q_a; activation_in = q_dat;
            patch_mask_in = q_m; activation_org = q_org;
            @(negedge clk);
        end
        resp_ready = 1'b1;
        @(negedge clk);
        chk("resp_done", {63'b0, resp_valid}, 64'd0);
        chk("idle_after_hs", {63'b0, req_ready}, 64'd1);
        exp_pend = 1'b0;
        if (rw && exp_hit) begin
            m_hits++;
            m_pl += $countones(mmask[ix]);
        end else if (rw && !err) begin
            m_misses++;
        end
        if (!rw && !err) begin
            mvld[ix] = 1'b1; maddr[ix] = a; mdat[ix] = dat; mmask[ix] = m;
        end
    endtask

    task automatic chk_reset_outputs();
        chk("rst_req_ready", {63'b0, req_ready}, 64'd1);
        chk("rst_resp_valid", {63'b0, resp_valid}, 64'd0);
        chk("rst_hit", {63'b0, hit}, 64'd0);
        chk("rst_error", {63'b0, error}, 64'd0);
        chk("rst_chosen", chosen_activation, 64'd0);
    endtask

    logic [W-1:0] org, org2, da, de;

    initial begin
        org  = pk(16'h1, 16'h2, 16'h3, 16'h4);
        org2 = pk(16'h11, 16'h22, 16'h33, 16'h44);
        da   = pk(16'hA, 16'hB, 16'hC, 16'hD);
        de   = pk(16'hE, 16'hF, 16'h10, 16'h12);

        repeat (3) @(negedge clk);
        chk_reset_outputs();
        reset = 1'b0;
`ifdef PATCH_CACHE_STATS_EN
        chk("stat_hits_rst", {32'b0, stat_hits}, 64'd0);
        chk("stat_misses_rst", {32'b0, stat_misses}, 64'd0);
        chk("stat_pl_rst", {32'b0, stat_patched_lanes}, 64'd0);
`endif

        txn(1'b1, 21'd5, '0, 4'b0, org, 0);
        chk("lit_cold_hit", {63'b0, last_hit}, 64'd0);
        chk("lit_cold_chosen", last_chosen, 64'h0004_0003_0002_0001);

        txn(1'b0, 21'd5, da, 4'b0101, '0, 0);
        chk("lit_wr_chosen", last_chosen, 64'd0);
        txn(1'b1, 21'd5, '0, 4'b0, org, 0);
        chk("lit_patch_hit", {63'b0, last_hit}, 64'd1);
        chk("lit_patch_chosen", last_chosen, 64'h0004_000C_0002_000A);

        txn(1'b1, 21'd69, '0, 4'b0, org2, 0);
        chk("lit_alias_hit", {63'b0, last_hit}, 64'd0);
        txn(1'b0, 21'd69, de, 4'b1111, '0, 0);
        txn(1'b1, 21'd5, '0, 4'b0, org, 0);
        chk("lit_replaced_hit", {63'b0, last_hit}, 64'd0);
        txn(1'b1, 21'd69, '0, 4'b0, org2, 0);
        chk("lit_full_mask", last_chosen, 64'h0012_0010_000F_000E);

        txn(1'b0, 21'd101, da, 4'b1111, '0, 0);
        chk("lit_wr_err", {63'b0, last_err}, 64'd1);
        txn(1'b1, 21'd101, '0, 4'b0, org, 0);
        chk("lit_rd_err", {63'b0, last_err}, 64'd1);
        chk("lit_rd_err_chosen", last_chosen, 64'h0004_0003_0002_0001);
        txn(1'b1, 21'd37, '0, 4'b0, org, 0);
        chk("lit_no_stale", {63'b0, last_hit}, 64'd0);

        txn(1'b0, 21'd100, da, 4'b1000, '0, 0);
        chk("lit_limit_err", {63'b0, last_err}, 64'd0);
        txn(1'b1, 21'd100, '0, 4'b0, org, 0);
        chk("lit_limit_chosen", last_chosen, 64'h000D_0003_0002_0001);

        q_rw = 1'b0; q_a = 21'd9; q_dat = de; q_m = 4'b1111; q_org = '0;
        txn(1'b1, 21'd69, '0, 4'b0, org2, 5);
        txn(1'b0, 21'd9, de, 4'b1111, '0, 0);
        txn(1'b1, 21'd9, '0, 4'b0, org, 0);
        chk("lit_queued_hit", {63'b0, last_hit}, 64'd1);
`ifdef PATCH_CACHE_STATS_EN
        chk("stat_hits_model", {32'b0, stat_hits}, 64'(m_hits));
        chk("stat_misses_model", {32'b0, stat_misses}, 64'(m_misses));
        chk("stat_pl_model", {32'b0, stat_patched_lanes}, 64'(m_pl));
`endif

        req_valid = 1'b1; read_write = 1'b0; address = 21'd20; activation_in = da; patch_mask_in = 4'b1111;
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b1;
        exp_pend = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        foreach (mvld[i]) mvld[i] = 1'b0;
        m_hits = 0; m_misses = 0; m_pl = 0;
        chk_reset_outputs();
        for (int c = 0; c < 3; c++) begin
            chk("no_resp_after_rst", {63'b0, resp_valid}, 64'd0);
            @(negedge clk);
        end
`ifdef PATCH_CACHE_STATS_EN
        chk("stat_hits_clr", {32'b0, stat_hits}, 64'd0);
        chk("stat_misses_clr", {32'b0, stat_misses}, 64'd0);
        chk("stat_pl_clr", {32'b0, stat_patched_lanes}, 64'd0);
`endif
        txn(1'b1, 21'd20, '0, 4'b0, org, 0);
        chk("lit_aborted_wr", {63'b0, last_hit}, 64'd0);
        txn(1'b1, 21'd69, '0, 4'b0, org2, 0);
        chk("lit_vld_cleared", {63'b0, last_hit}, 64'd0);

        txn(1'b0, 21'd30, da, 4'b0111, '0, 0);
        txn(1'b1, 21'd30, '0, 4'b0, org, 0);
        txn(1'b1, 21'd30, '0, 4'b0, org2, 0);
        chk("lit_mask7_chosen", last_chosen, 64'h0044_000C_000B_000A);
`ifdef PATCH_CACHE_STATS_EN
        chk("stat_hits_two", {32'b0, stat_hits}, 64'd2);
        chk("stat_pl_six", {32'b0, stat_patched_lanes}, 64'd6);
        chk("stat_misses_two", {32'b0, stat_misses}, 64'd2);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
